// File: rtl/ftc_pkg.sv
// ============================================================================
// Module   : ftc_pkg
// Brief    : Forbidden-transition code constants and 3b<->4b symbol mapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ftc_pkg;

    localparam int FTC_CW = 4;
    localparam int FTC_SW = 3;

    function automatic logic [FTC_CW-1:0] ftc_encode3(input logic [FTC_SW-1:0] sym);
        logic [FTC_CW-1:0] cw;
        case (sym)
            3'b000:  cw = 4'b0000;
            3'b001:  cw = 4'b0100;
            3'b010:  cw = 4'b0001;
            3'b011:  cw = 4'b0101;
            3'b100:  cw = 4'b0111;
            3'b101:  cw = 4'b1100;
            3'b110:  cw = 4'b1101;
            default: cw = 4'b1111;
        endcase
        return cw;
    endfunction

    // Codewords outside the legal set decode to 0.
    function automatic logic [FTC_SW-1:0] ftc_decode4(input logic [FTC_CW-1:0] cw);
        logic [FTC_SW-1:0] sym;
        case (cw)
            4'b0100: sym = 3'b001;
            4'b0001: sym = 3'b010;
            4'b0101: sym = 3'b011;
            4'b0111: sym = 3'b100;
            4'b1100: sym = 3'b101;
            4'b1101: sym = 3'b110;
            4'b1111: sym = 3'b111;
            default: sym = 3'b000;
        endcase
        return sym;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ftc_skid_buf.sv
// ============================================================================
// Module   : ftc_skid_buf
// Brief    : One-entry skid register catching a word when the output stage stalls.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ftc_skid_buf #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    input  logic         i_load,
    output logic         o_ready,
    output logic         o_xfer,
    output logic         o_full,
    output logic [W-1:0] o_data
);

    logic         r_full;
    logic [W-1:0] r_data;

    assign o_ready = ~r_full;
    assign o_xfer  = i_valid & ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

    // A loading output stage always drains the skid entry (or bypasses it).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b0;
        end else if (o_xfer) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ftc_enc_pipe.sv
// ============================================================================
// Module   : ftc_enc_pipe
// Brief    : Streaming FTC encoder with registered valid/ready output and skid.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ftc_enc_pipe
    import ftc_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [FTC_CW*DATA_W/3-1:0]  out_code,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            word_cnt
);

    localparam int NG     = DATA_W / FTC_SW;
    localparam int CODE_W = FTC_CW * NG;

    if (DATA_W == 0 || (DATA_W % FTC_SW) != 0) begin : g_bad_width
        $error("ftc_enc_pipe: DATA_W must be a nonzero multiple of 3");
    end

    logic              r_valid;
    logic [CODE_W-1:0] r_code;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_load;
    logic              w_in_xfer;
    logic              w_s_full;
    logic [DATA_W-1:0] w_s_data;
    logic [DATA_W-1:0] w_src;
    logic [CODE_W-1:0] w_code;

    assign w_load = ~r_valid | out_ready;

    ftc_skid_buf #(
        .W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (in_data),
        .i_valid (in_valid),
        .i_load  (w_load),
        .o_ready (in_ready),
        .o_xfer  (w_in_xfer),
        .o_full  (w_s_full),
        .o_data  (w_s_data)
    );

    // The skid entry is older than anything on the input, so it goes first.
    assign w_src = w_s_full ? w_s_data : in_data;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        assign w_code[FTC_CW*g +: FTC_CW] = ftc_encode3(w_src[FTC_SW*g +: FTC_SW]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_code  <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_valid && out_ready) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_load) begin
                if (w_s_full || w_in_xfer) begin
                    r_code  <= w_code;
                    r_valid <= 1'b1;
                end else begin
                    // Idle bus keeps the last codeword to avoid transitions.
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign out_code  = r_code;
    assign out_valid = r_valid;
    assign word_cnt  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ftc_enc_pipe.sv
// ============================================================================
// Module   : tb_ftc_enc_pipe
// Brief    : Scoreboard bench for ftc_enc_pipe at DATA_W=6, CNT_W=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ftc_enc_pipe;

    localparam int DW = 6;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_code;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] word_cnt;

    int checks = 0;
    int errors = 0;

    logic [3:0] c_map [0:7] = '{4'h0, 4'h4, 4'h1, 4'h5, 4'h7, 4'hC, 4'hD, 4'hF};
    logic [7:0] sb [$];
    logic [CW-1:0] m_cnt = '0;
    logic       have_prev = 1'b0;
    logic       prev_valid, prev_ready;
    logic [7:0] prev_code;

    ftc_enc_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] enc6(input logic [5:0] d);
        return {c_map[d[5:3]], c_map[d[2:0]]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: sampled at negedge, describing the coming posedge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            m_cnt = '0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                if (prev_valid && !prev_ready) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_code !== prev_code) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b code=%h required valid=1 code=%h",
                                 out_valid, out_code, prev_code);
                    end
                end else if (!out_valid) begin
                    checks++;
                    if (out_code !== prev_code) begin
                        errors++;
                        $display("FAIL idle_hold: code=%h required %h", out_code, prev_code);
                    end
                end
            end
            checks++;
            if (word_cnt !== m_cnt) begin
                errors++;
                $display("FAIL word_cnt_track: got %0d required %0d", word_cnt, m_cnt);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: code=%h emitted with nothing outstanding", out_code);
                end else begin
                    logic [7:0] exp_code;
                    exp_code = sb.pop_front();
                    if (out_code !== exp_code) begin
                        errors++;
                        $display("FAIL sb_order: got %h required %h", out_code, exp_code);
                    end
                end
                m_cnt = m_cnt + 1'b1;
            end
            if (in_valid && in_ready) begin
                sb.push_back(enc6(in_data));
            end
            have_prev  = 1'b1;
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_code  = out_code;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_code !== 8'h00 || in_ready !== 1'b1 || word_cnt !== '0) begin
                errors++;
                $display("FAIL reset_idle: valid=%b code=%h ready=%b cnt=%0d required 0/00/1/0",
                         out_valid, out_code, in_ready, word_cnt);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        in_data   = 6'b101_011;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_code !== 8'hC5) begin
            errors++;
            $display("FAIL single_out: valid=%b code=%h required 1/C5", out_valid, out_code);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_code !== 8'hC5 || word_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_after: valid=%b code=%h cnt=%0d required 0/C5/1",
                     out_valid, out_code, word_cnt);
        end
    endtask

    task automatic test_map();
        logic [7:0] exp_code;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data  = {3'(7 - i), 3'(i)};
            in_valid = 1'b1;
            tick();
            exp_code = {c_map[7 - i], c_map[i]};
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp_code) begin
                errors++;
                $display("FAIL map_%0d: valid=%b code=%h required 1/%h", i, out_valid, out_code, exp_code);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (word_cnt !== 4'd8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL map_cnt: cnt=%0d valid=%b required 8/0", word_cnt, out_valid);
        end
    endtask

    task automatic fill_both(input logic [5:0] a, input logic [5:0] b);
        out_ready = 1'b0;
        in_data = a;
        in_valid = 1'b1;
        tick();
        in_data = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        fill_both(6'o52, 6'o17);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_code !== enc6(6'o52)) begin
                errors++;
                $display("FAIL bp_hold: ready=%b valid=%b code=%h required 0/1/%h",
                         in_ready, out_valid, out_code, enc6(6'o52));
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_code !== enc6(6'o17) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b code=%h ready=%b required 1/%h/1",
                     out_valid, out_code, in_ready, enc6(6'o17));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || word_cnt !== 4'd2) begin
            errors++;
            $display("FAIL bp_drain: valid=%b cnt=%0d required 0/2", out_valid, word_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        fill_both(6'o33, 6'o44);
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 6'o77;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_code !== 8'h00 || in_ready !== 1'b1 || word_cnt !== '0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b code=%h ready=%b cnt=%0d required 0/00/1/0",
                     out_valid, out_code, in_ready, word_cnt);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_ghost: code=%h valid=%b required valid 0", out_code, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            acc = in_valid && in_ready;
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 6'($urandom);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb.size() != 0 || out_valid); i++) tick();
        tick();
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: %0d words outstanding valid=%b required 0/0", sb.size(), out_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 6'(i * 5);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (word_cnt !== 4'd1) begin
            errors++;
            $display("FAIL cnt_wrap: got %0d required 1", word_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_map();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
